// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle ALU ops plus an optional iterative multiply/divide unit.
// Build option: define ALU_MULDIV_EN to include the MUL/DIV states and their datapath.
`ifndef OPAND
`define OPAND    0
`define OPOR     1
`define OPXOR    2
`define OPADD    3
`define OPSUB    4
`define OPSLT    5
`define OPSLTU   6
`define OPSLL    7
`define OPSRL    8
`define OPSRA    9
`define OPLUI    10
`define OPMUL    11
`define OPMULH   12
`define OPMULHU  13
`define OPMULHSU 14
`define OPDIV    15
`define OPDIVU   16
`define OPREM    17
`define OPREMU   18
`endif

// state | meaning
// IDLE  | waiting for a request
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIN   | oResult valid and oDone high; a new request may be accepted
module multicycle_alu #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic [CTRL_W-1:0] iControl,
  input  logic [WIDTH-1:0]  iA,
  input  logic [WIDTH-1:0]  iB,
  output logic              oReady,
  output logic              oDone,
  output logic [WIDTH-1:0]  oResult,
  output logic              oZero
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FIN  = 2'd1;

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(`OPAND);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(`OPOR);
  localparam logic [CTRL_W-1:0] OP_XOR  = CTRL_W'(`OPXOR);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(`OPADD);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(`OPSUB);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(`OPSLT);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(`OPSLTU);
  localparam logic [CTRL_W-1:0] OP_SLL  = CTRL_W'(`OPSLL);
  localparam logic [CTRL_W-1:0] OP_SRL  = CTRL_W'(`OPSRL);
  localparam logic [CTRL_W-1:0] OP_SRA  = CTRL_W'(`OPSRA);
  localparam logic [CTRL_W-1:0] OP_LUI  = CTRL_W'(`OPLUI);

  logic [1:0]       state;
  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] fast_res;

  assign oReady = (state == IDLE) || (state == FIN);
  assign oDone  = (state == FIN);
  assign oZero  = (oResult == '0);
  assign accept = iStart && oReady;
  assign shamt  = iB[SHW-1:0];

`ifdef ALU_MULDIV_EN
  localparam logic [1:0] MUL = 2'd2;
  localparam logic [1:0] DIV = 2'd3;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CTRL_W-1:0] OP_MUL    = CTRL_W'(`OPMUL);
  localparam logic [CTRL_W-1:0] OP_MULH   = CTRL_W'(`OPMULH);
  localparam logic [CTRL_W-1:0] OP_MULHU  = CTRL_W'(`OPMULHU);
  localparam logic [CTRL_W-1:0] OP_MULHSU = CTRL_W'(`OPMULHSU);
  localparam logic [CTRL_W-1:0] OP_DIV    = CTRL_W'(`OPDIV);
  localparam logic [CTRL_W-1:0] OP_DIVU   = CTRL_W'(`OPDIVU);
  localparam logic [CTRL_W-1:0] OP_REM    = CTRL_W'(`OPREM);
  localparam logic [CTRL_W-1:0] OP_REMU   = CTRL_W'(`OPREMU);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;  // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;
  logic               neg, sel_hi;
  logic               is_mul, is_div, sgn_a, sgn_b, div_zero, div_ovf, div_ge;
  logic [WIDTH-1:0]   mag_a, mag_b, div_sub, div_half, mul_res, div_res;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [2*WIDTH-1:0] acc_nxt, mul_full;

  assign is_mul   = iControl inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
  assign is_div   = iControl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign sgn_a    = iA[WIDTH-1] && (iControl inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sgn_b    = iB[WIDTH-1] && (iControl inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign mag_a    = sgn_a ? -iA : iA;
  assign mag_b    = sgn_b ? -iB : iB;
  assign div_zero = (iB == '0);
  assign div_ovf  = (iControl inside {OP_DIV, OP_REM}) &&
                    (iA == {1'b1, {(WIDTH-1){1'b0}}}) && (&iB);

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_sub   = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
  assign acc_nxt   = (state == MUL) ? {mul_sum, acc[WIDTH-1:1]}
                                    : {div_sub, acc[WIDTH-2:0], div_ge};

  // Sign is applied to the finished magnitude on the same edge as the last iteration.
  assign mul_full = neg ? -acc_nxt : acc_nxt;
  assign mul_res  = sel_hi ? mul_full[2*WIDTH-1:WIDTH] : mul_full[WIDTH-1:0];
  assign div_half = sel_hi ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
  assign div_res  = neg ? -div_half : div_half;
`endif

  always_comb begin
    fast_res = '0;
    case (iControl)
      OP_AND:  fast_res = iA & iB;
      OP_OR:   fast_res = iA | iB;
      OP_XOR:  fast_res = iA ^ iB;
      OP_ADD:  fast_res = iA + iB;
      OP_SUB:  fast_res = iA - iB;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, $signed(iA) < $signed(iB)};
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, iA < iB};
      OP_SLL:  fast_res = iA << shamt;
      OP_SRL:  fast_res = iA >> shamt;
      OP_SRA:  fast_res = $signed(iA) >>> shamt;
      OP_LUI:  fast_res = iB;
`ifdef ALU_MULDIV_EN
      // Only divide-by-zero and signed overflow reach here; normal divides iterate.
      OP_DIV, OP_DIVU: fast_res = div_zero ? '1 : iA;
      OP_REM, OP_REMU: fast_res = div_zero ? iA : '0;
`endif
      default: fast_res = '0;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= IDLE;
      oResult <= '0;
`ifdef ALU_MULDIV_EN
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg    <= 1'b0;
      sel_hi <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (is_mul || (is_div && !div_zero && !div_ovf)) begin
              state  <= is_mul ? MUL : DIV;
              cnt    <= CW'(WIDTH);
              acc    <= {{WIDTH{1'b0}}, is_mul ? mag_b : mag_a};
              opnd   <= is_mul ? mag_a : mag_b;
              neg    <= (iControl inside {OP_REM, OP_REMU}) ? sgn_a : (sgn_a ^ sgn_b);
              sel_hi <= iControl inside {OP_MULH, OP_MULHU, OP_MULHSU, OP_REM, OP_REMU};
            end else begin
              state   <= FIN;
              oResult <= fast_res;
            end
`else
            state   <= FIN;
            oResult <= fast_res;
`endif
          end
        end
`ifdef ALU_MULDIV_EN
        MUL, DIV: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= FIN;
            oResult <= (state == MUL) ? mul_res : div_res;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: vector table, hand-written multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
`ifndef OPAND
`define OPAND    0
`define OPOR     1
`define OPXOR    2
`define OPADD    3
`define OPSUB    4
`define OPSLT    5
`define OPSLTU   6
`define OPSLL    7
`define OPSRL    8
`define OPSRA    9
`define OPLUI    10
`define OPMUL    11
`define OPMULH   12
`define OPMULHU  13
`define OPMULHSU 14
`define OPDIV    15
`define OPDIVU   16
`define OPREM    17
`define OPREMU   18
`endif

module tb_multicycle_alu;
  localparam int W  = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst, start, ready, done, zero;
  logic [CW-1:0] ctl;
  logic [W-1:0]  a, b, result;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W), .CTRL_W(CW)) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iControl(ctl), .iA(a), .iB(b),
    .oReady(ready), .oDone(done), .oResult(result), .oZero(zero)
  );

  typedef struct {
    string         name;
    logic [CW-1:0] op;
    logic [W-1:0]  x, y, res;
    int            lat;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input string n, input int op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic [W-1:0] r, input int lat);
    vec_t v;
    v.name = n; v.op = CW'(op); v.x = x; v.y = y; v.res = r; v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Reference: plain 64-bit arithmetic on the operand values.
  function automatic logic [W-1:0] model(input logic [CW-1:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    p  = '0;
    case (int'(op))
      `OPAND:  return x & y;
      `OPOR:   return x | y;
      `OPXOR:  return x ^ y;
      `OPADD:  return x + y;
      `OPSUB:  return x - y;
      `OPSLT:  return (sx < sy) ? 32'd1 : 32'd0;
      `OPSLTU: return (ux < uy) ? 32'd1 : 32'd0;
      `OPSLL:  return x << y[4:0];
      `OPSRL:  return x >> y[4:0];
      `OPSRA:  begin p = sx >>> y[4:0]; return p[31:0]; end
      `OPLUI:  return y;
`ifdef ALU_MULDIV_EN
      `OPMUL:    begin p = sx * sy; return p[31:0]; end
      `OPMULH:   begin p = sx * sy; return p[63:32]; end
      `OPMULHU:  begin p = ux * uy; return p[63:32]; end
      `OPMULHSU: begin p = sx * uy; return p[63:32]; end
      `OPDIV:    begin if (y == 0) return '1; p = sx / sy; return p[31:0]; end
      `OPDIVU:   begin if (y == 0) return '1; p = ux / uy; return p[31:0]; end
      `OPREM:    begin if (y == 0) return x;  p = sx % sy; return p[31:0]; end
      `OPREMU:   begin if (y == 0) return x;  p = ux % uy; return p[31:0]; end
`endif
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [CW-1:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
`ifdef ALU_MULDIV_EN
    if (int'(op) inside {`OPMUL, `OPMULH, `OPMULHU, `OPMULHSU}) return W + 1;
    if (int'(op) inside {`OPDIVU, `OPREMU} && y != 0) return W + 1;
    if (int'(op) inside {`OPDIV, `OPREM} && y != 0 &&
        !(x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return W + 1;
`endif
    return 1;
  endfunction

  // Called at a negedge with the DUT idle or in FIN; returns at the negedge where oDone is seen.
  task automatic run_op(input string name, input logic [CW-1:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp, input int exp_lat);
    logic [W-1:0] prev;
    int           lat;
    bit           stable;
    chk({name, " ready"}, 64'(ready), 64'd1);
    prev = result;
    start = 1'b1; ctl = op; a = x; b = y;
    lat = 0; stable = 1'b1;
    for (int n = 1; n <= 2 * W + 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; ctl = CW'($urandom); a = $urandom; b = $urandom;
      end
      if (done) begin
        lat = n;
        break;
      end
      if (result !== prev) stable = 1'b0;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, 64'(result), 64'(exp));
    chk({name, " zero"}, 64'(zero), 64'(exp == '0));
    if (exp_lat > 1) chk({name, " stable_while_busy"}, 64'(stable), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           ndone, first;
    bit           stable;
    logic [W-1:0] got;
    logic [CW-1:0] rop;
    logic [W-1:0]  rx, ry;

    rst = 1'b1; start = 1'b0; ctl = '0; a = '0; b = '0;

    add_vec("add_7_m3",   `OPADD,  32'd7,          32'hFFFF_FFFD, 32'd4,          1);
    add_vec("sub_5_7",    `OPSUB,  32'd5,          32'd7,         32'hFFFF_FFFE,  1);
    add_vec("and",        `OPAND,  32'hF0F0_F0F0,  32'hFF00_FF00, 32'hF000_F000,  1);
    add_vec("or",         `OPOR,   32'hF0F0_F0F0,  32'h0F0F_0F0F, 32'hFFFF_FFFF,  1);
    add_vec("xor_zero",   `OPXOR,  32'hAAAA_5555,  32'hAAAA_5555, 32'h0,          1);
    add_vec("slt_m1_1",   `OPSLT,  32'hFFFF_FFFF,  32'd1,         32'd1,          1);
    add_vec("sltu_big_1", `OPSLTU, 32'hFFFF_FFFF,  32'd1,         32'd0,          1);
    add_vec("sll_sh33",   `OPSLL,  32'd1,          32'd33,        32'd2,          1);
    add_vec("srl_31",     `OPSRL,  32'h8000_0000,  32'd31,        32'd1,          1);
    add_vec("sra_4",      `OPSRA,  32'h8000_0000,  32'd4,         32'hF800_0000,  1);
    add_vec("lui",        `OPLUI,  32'hDEAD_BEEF,  32'h1234_5000, 32'h1234_5000,  1);
    add_vec("unknown_31", 31,      32'd3,          32'd4,         32'h0,          1);
`ifdef ALU_MULDIV_EN
    add_vec("mulh_min_2", `OPMULH,   32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 33);
    add_vec("mul_min_2",  `OPMUL,    32'h8000_0000, 32'd2,         32'h0,         33);
    add_vec("mul_m3_5",   `OPMUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33);
    add_vec("mulhu_max",  `OPMULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    add_vec("mulhsu_m1",  `OPMULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    add_vec("div_m7_2",   `OPDIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    add_vec("rem_m7_2",   `OPREM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    add_vec("remu_100_7", `OPREMU,   32'd100,       32'd7,         32'd2,         33);
    add_vec("divu_by0",   `OPDIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    add_vec("remu_by0",   `OPREMU,   32'd9,         32'd0,         32'd9,         1);
    add_vec("rem_ovf",    `OPREM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    add_vec("div_ovf",    `OPDIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
`else
    add_vec("mul_3_4_off",  `OPMUL,  32'd3,          32'd4, 32'h0, 1);
    add_vec("mulh_off",     `OPMULH, 32'h8000_0000,  32'd2, 32'h0, 1);
    add_vec("div_off",      `OPDIV,  32'hFFFF_FFF9,  32'd2, 32'h0, 1);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset zero", 64'(zero), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Table, applied back-to-back (each accept happens while in FIN)
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].lat);

    // oDone lasts one cycle, then FIN falls back to IDLE
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_ready", 64'(ready), 64'd1);

    // Reset wins over a same-cycle start
    run_op("pre_rst_prio", CW'(`OPADD), 32'd20, 32'd22, 32'd42, 1);
    rst = 1'b1; start = 1'b1; ctl = CW'(`OPADD); a = 32'd1; b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio done", 64'(done), 64'd0);
    chk("rst_prio result", 64'(result), 64'd0);
    chk("rst_prio ready", 64'(ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("rst_prio no_late_accept", 64'(done), 64'd0);

`ifdef ALU_MULDIV_EN
    // iStart pulse while multiplying is dropped, not queued
    run_op("pre_busy", CW'(`OPADD), 32'd1, 32'd1, 32'd2, 1);
    start = 1'b1; ctl = CW'(`OPMUL); a = 32'd3; b = 32'd5;
    ndone = 0; first = 0; stable = 1'b1; got = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = (n == 4);
      if (n == 4) begin ctl = CW'(`OPADD); a = 32'd100; b = 32'd1; end
      if (done) begin
        ndone++;
        if (first == 0) begin first = n; got = result; end
      end else if (first == 0 && result !== 32'd2) stable = 1'b0;
    end
    chk("busy_ignore done_count", 64'(ndone), 64'd1);
    chk("busy_ignore latency", 64'(first), 64'(W + 1));
    chk("busy_ignore result", 64'(got), 64'd15);
    chk("busy_ignore stable", 64'(stable), 64'd1);

    // Reset mid-multiply aborts without oDone
    start = 1'b1; ctl = CW'(`OPMUL); a = 32'd7; b = 32'd9;
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      start = (n == 4);
      rst = (n == 9);
      if (done) ndone++;
    end
    chk("abort no_done", 64'(ndone), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort ready", 64'(ready), 64'd1);
    chk("abort zero", 64'(zero), 64'd1);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no_late_done", 64'(ndone), 64'd0);
`endif

    // Randomized operations, sometimes back-to-back, sometimes with idle gaps
    for (int i = 0; i < 80; i++) begin
      rop = CW'($urandom_range(0, 20));
      rx = pick();
      ry = pick();
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, rx, ry, model(rop, rx, ry),
             model_lat(rop, rx, ry));
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
